spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder model for system-side verification.
// Emulates a small byte-addressable array behind a mode-0 SPI slave.
// Supported opcodes: WREN 06, READ 03, PP 02, SE D8, BE C7, RFSR 70.
// Program/erase busy time is counted in SYS_CLK cycles.
// An erase sweep rewrites the whole array to 0xFF, one byte per cycle.
module spi_flash_responder #(
   parameter int C_MEM_ADDR_W          = 8,
   parameter int C_PROG_BUSY_CLK_NUM   = 100,
   parameter int C_ERASE_EXTRA_CLK_NUM = 200
) (
   input  logic       SYS_CLK_I,
   input  logic       SYS_RST_I,
   input  logic       FLASH_CLK_I,
   input  logic       FLASH_CS_I,
   input  logic       FLASH_D0_I,
   output logic       FLASH_D1_O,
   input  logic       FLASH_WP_I,
   input  logic       FLASH_HOLD_I,
   output logic       BUSY_O,
   output logic       WEL_O,
   output logic [7:0] CMD_O,
   output logic       CMD_VALID_O
);

   localparam int                      C_DEPTH   = 1 << C_MEM_ADDR_W;
   localparam logic [C_MEM_ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [C_MEM_ADDR_W-1:0] ADDR_MAX  = {C_MEM_ADDR_W{1'b1}};
   localparam logic [15:0]             PROG_CNT  = 16'(C_PROG_BUSY_CLK_NUM);
   localparam logic [15:0]             ERASE_CNT = 16'(C_ERASE_EXTRA_CLK_NUM);

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_SE   = 8'hD8;
   localparam logic [7:0] OP_BE   = 8'hC7;
   localparam logic [7:0] OP_RFSR = 8'h70;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RD, S_PP, S_STAT, S_IGNORE
   } state_t;

   // Write-protect and hold are accepted but have no effect.
   logic unused_pins;
   assign unused_pins = FLASH_WP_I ^ FLASH_HOLD_I;

   // Emulated array; starts erased and survives reset.
   logic [7:0] mem_q [0:C_DEPTH-1] = '{default: 8'hFF};

   logic [1:0] sck_sync_q, cs_sync_q, d0_sync_q;
   logic       sck_prev_q, cs_prev_q;
   logic       sck_s, cs_s, d0_s;
   logic       sck_rise, sck_fall, cs_fall, cs_rise;

   state_t                  state_q, state_d;
   logic [5:0]              tot_q, tot_d;      // bits in transaction, saturating
   logic [2:0]              bit_q, bit_d;      // bit position within current byte
   logic [6:0]              sh_q, sh_d;
   logic [C_MEM_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]              op_q, op_d;        // accepted write-class/read opcode
   logic                    pp_wr_q, pp_wr_d;  // at least one PP byte stored
   logic [7:0]              out_q, out_d;      // byte being shifted out on D1
   logic                    d1_q, d1_d;
   logic [7:0]              cmd_q, cmd_d;
   logic                    cmd_vld_q, cmd_vld_d;

   logic                    busy_q, busy_d;
   logic                    wel_q, wel_d;
   logic                    erase_q, erase_d;
   logic [C_MEM_ADDR_W-1:0] ea_q, ea_d;
   logic [15:0]             bcnt_q, bcnt_d;

   logic [7:0]              rx_byte, stat_byte, mem_rd, pp_wd;
   logic                    pp_we;
   logic                    mem_we;
   logic [C_MEM_ADDR_W-1:0] mem_wa;
   logic [7:0]              mem_wd;

   assign sck_s    = sck_sync_q[1];
   assign cs_s     = cs_sync_q[1];
   assign d0_s     = d0_sync_q[1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   // cs_prev_q resets low, so a falling edge needs CS to have been seen high first.
   assign cs_fall  = cs_prev_q & ~cs_s;
   assign cs_rise  = ~cs_prev_q & cs_s;

   assign rx_byte   = {sh_q, d0_s};
   assign stat_byte = {~busy_q, 7'b0};
   assign mem_rd    = mem_q[addr_q];

   // Two-stage synchronizers and edge-detect history for the SPI pins.
   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         sck_sync_q <= '0;
         cs_sync_q  <= '0;
         d0_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         cs_prev_q  <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[0], FLASH_CLK_I};
         cs_sync_q  <= {cs_sync_q[0], FLASH_CS_I};
         d0_sync_q  <= {d0_sync_q[0], FLASH_D0_I};
         sck_prev_q <= sck_s;
         cs_prev_q  <= cs_s;
      end
   end

   // SPI protocol state register.
   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         state_q   <= S_IDLE;
         tot_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         addr_q    <= '0;
         op_q      <= '0;
         pp_wr_q   <= 1'b0;
         out_q     <= '0;
         d1_q      <= 1'b0;
         cmd_q     <= '0;
         cmd_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tot_q     <= tot_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         addr_q    <= addr_d;
         op_q      <= op_d;
         pp_wr_q   <= pp_wr_d;
         out_q     <= out_d;
         d1_q      <= d1_d;
         cmd_q     <= cmd_d;
         cmd_vld_q <= cmd_vld_d;
      end
   end

   // SPI protocol next state: bit collection, decode, D1 shifting, PP writes.
   always_comb begin
      state_d   = state_q;
      tot_d     = tot_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      addr_d    = addr_q;
      op_d      = op_q;
      pp_wr_d   = pp_wr_q;
      out_d     = out_q;
      d1_d      = d1_q;
      cmd_d     = cmd_q;
      cmd_vld_d = 1'b0;
      pp_we     = 1'b0;
      pp_wd     = 8'h00;
      if (cs_s) begin
         state_d = S_IDLE;
         tot_d   = '0;
         bit_d   = '0;
         op_d    = '0;
         pp_wr_d = 1'b0;
         d1_d    = 1'b0;
      end else if (state_q == S_IDLE) begin
         d1_d = 1'b0;
         if (cs_fall) begin
            state_d = S_CMD;
            tot_d   = '0;
            bit_d   = '0;
         end
      end else begin
         if (sck_rise) begin
            sh_d  = rx_byte[6:0];
            bit_d = bit_q + 3'd1;
            if (tot_q != 6'h3F) tot_d = tot_q + 6'd1;
         end
         case (state_q)
            S_CMD: begin
               d1_d = 1'b0;
               if (sck_rise && bit_q == 3'd7) begin
                  cmd_d     = rx_byte;
                  cmd_vld_d = 1'b1;
                  if (busy_q) begin
                     state_d = (rx_byte == OP_RFSR) ? S_STAT : S_IGNORE;
                  end else begin
                     case (rx_byte)
                        OP_WREN, OP_BE: begin
                           state_d = S_IGNORE;
                           op_d    = rx_byte;
                        end
                        OP_READ, OP_PP, OP_SE: begin
                           state_d = S_ADDR;
                           op_d    = rx_byte;
                        end
                        OP_RFSR: state_d = S_STAT;
                        default: state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               d1_d = 1'b0;
               if (sck_rise) begin
                  addr_d = {addr_q[C_MEM_ADDR_W-2:0], d0_s};
                  if (tot_q == 6'd31) begin
                     case (op_q)
                        OP_READ: state_d = S_RD;
                        OP_PP:   state_d = S_PP;
                        default: state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            S_RD: begin
               if (sck_rise && bit_q == 3'd7) addr_d = addr_q + ADDR_ONE;
               if (sck_fall) begin
                  if (bit_q == 3'd0) begin
                     out_d = mem_rd;
                     d1_d  = mem_rd[7];
                  end else begin
                     d1_d = out_q[~bit_q];
                  end
               end
            end
            S_STAT: begin
               if (sck_fall) begin
                  if (bit_q == 3'd0) begin
                     out_d = stat_byte;
                     d1_d  = stat_byte[7];
                  end else begin
                     d1_d = out_q[~bit_q];
                  end
               end
            end
            S_PP: begin
               d1_d = 1'b0;
               if (sck_rise && bit_q == 3'd7) begin
                  if (wel_q) begin
                     pp_we   = 1'b1;
                     pp_wd   = rx_byte;
                     pp_wr_d = 1'b1;
                  end
                  addr_d = addr_q + ADDR_ONE;
               end
            end
            default: d1_d = 1'b0;
         endcase
      end
   end

   // Busy / write-enable / erase-sweep control register.
   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         busy_q  <= 1'b0;
         wel_q   <= 1'b0;
         erase_q <= 1'b0;
         ea_q    <= '0;
         bcnt_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         wel_q   <= wel_d;
         erase_q <= erase_d;
         ea_q    <= ea_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Busy countdown, erase sweep stepping, and commit of commands at CS rise.
   always_comb begin
      busy_d  = busy_q;
      wel_d   = wel_q;
      erase_d = erase_q;
      ea_d    = ea_q;
      bcnt_d  = bcnt_q;
      if (erase_q) begin
         if (ea_q == ADDR_MAX) begin
            erase_d = 1'b0;
            bcnt_d  = ERASE_CNT;
         end else begin
            ea_d = ea_q + ADDR_ONE;
         end
      end else if (busy_q) begin
         if (bcnt_q <= 16'd1) busy_d = 1'b0;
         else                 bcnt_d = bcnt_q - 16'd1;
      end
      // op_q is only set for commands accepted while not busy.
      if (cs_rise) begin
         case (op_q)
            OP_WREN: if (tot_q == 6'd8) wel_d = 1'b1;
            OP_PP: begin
               if (pp_wr_q && wel_q) begin
                  busy_d = 1'b1;
                  bcnt_d = PROG_CNT;
                  wel_d  = 1'b0;
               end
            end
            OP_SE, OP_BE: begin
               if (wel_q && ((op_q == OP_SE && tot_q == 6'd32) ||
                             (op_q == OP_BE && tot_q == 6'd8))) begin
                  erase_d = 1'b1;
                  ea_d    = '0;
                  busy_d  = 1'b1;
                  wel_d   = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Single write port: the erase sweep and page program never overlap.
   always_comb begin
      mem_we = erase_q | pp_we;
      mem_wa = erase_q ? ea_q : addr_q;
      mem_wd = erase_q ? 8'hFF : pp_wd;
   end

   // Array write port (no reset: contents persist).
   always_ff @(posedge SYS_CLK_I) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   assign FLASH_D1_O  = d1_q;
   assign BUSY_O      = busy_q;
   assign WEL_O       = wel_q;
   assign CMD_O       = cmd_q;
   assign CMD_VALID_O = cmd_vld_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder with default parameters.
module tb_spi_flash_responder;

   localparam int HALF = 50;   // SCK half period in ns (5 SYS_CLK cycles)

   logic       clk = 1'b0;
   logic       rst;
   logic       sck, cs, d0, wp, hold;
   logic       d1, busy, wel, cmdv;
   logic [7:0] cmd;

   int checks = 0;
   int errors = 0;
   int busy_cyc = 0;
   int cv_cnt = 0;
   int d1_hi = 0;

   logic [7:0] r0, r1, st;
   int         b0, cv0, h0;

   spi_flash_responder dut (
      .SYS_CLK_I   (clk),
      .SYS_RST_I   (rst),
      .FLASH_CLK_I (sck),
      .FLASH_CS_I  (cs),
      .FLASH_D0_I  (d0),
      .FLASH_D1_O  (d1),
      .FLASH_WP_I  (wp),
      .FLASH_HOLD_I(hold),
      .BUSY_O      (busy),
      .WEL_O       (wel),
      .CMD_O       (cmd),
      .CMD_VALID_O (cmdv)
   );

   always #5 clk = ~clk;

   // Cycle counters for busy length, opcode pulses and D1 activity.
   always @(posedge clk) begin
      if (busy) busy_cyc++;
      if (cmdv) cv_cnt++;
      if (d1)   d1_hi++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cs_begin();
      @(negedge clk);
      sck = 1'b0;
      cs  = 1'b0;
      #(HALF);
   endtask

   task automatic cs_end();
      #(HALF);
      cs = 1'b1;
      #(3*HALF);
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         d0 = tx[i];
         #(HALF);
         rx[i] = d1;
         sck = 1'b1;
         #(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
      logic [7:0] dmy;
      xfer(op, dmy);
      xfer(a[23:16], dmy);
      xfer(a[15:8], dmy);
      xfer(a[7:0], dmy);
   endtask

   task automatic cmd1(input logic [7:0] op);
      logic [7:0] dmy;
      cs_begin();
      xfer(op, dmy);
      cs_end();
   endtask

   task automatic pp2(input logic [23:0] a, input logic [7:0] x0, input logic [7:0] x1);
      logic [7:0] dmy;
      cs_begin();
      send_hdr(8'h02, a);
      xfer(x0, dmy);
      xfer(x1, dmy);
      cs_end();
   endtask

   task automatic read2(input logic [23:0] a, output logic [7:0] y0, output logic [7:0] y1);
      cs_begin();
      send_hdr(8'h03, a);
      xfer(8'h00, y0);
      xfer(8'h00, y1);
      cs_end();
   endtask

   task automatic rfsr(output logic [7:0] s);
      logic [7:0] dmy;
      cs_begin();
      xfer(8'h70, dmy);
      xfer(8'h00, s);
      cs_end();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cs = 1'b1; sck = 1'b0; d0 = 1'b0; wp = 1'b0; hold = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_d1", {31'b0, d1}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_wel", {31'b0, wel}, 0);
      check("rst_cmd", {24'b0, cmd}, 0);
      check("rst_cmdv", {31'b0, cmdv}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // WREN then page program of two bytes at 0x10
      cmd1(8'h06);
      check("wren_wel", {31'b0, wel}, 1);
      check("wren_cmd", {24'b0, cmd}, 32'h06);
      b0 = busy_cyc;
      pp2(24'h000010, 8'hA5, 8'h5A);
      check("pp_wel_clr", {31'b0, wel}, 0);
      check("pp_busy", {31'b0, busy}, 1);
      wait_idle("pp_busy_end");
      check("pp_busy_len", busy_cyc - b0, 100);
      read2(24'h000010, r0, r1);
      check("rd10_b0", {24'b0, r0}, 32'hA5);
      check("rd10_b1", {24'b0, r1}, 32'h5A);

      // Program without WREN has no effect
      pp2(24'h000020, 8'h11, 8'h22);
      check("nowel_busy", {31'b0, busy}, 0);
      check("nowel_wel", {31'b0, wel}, 0);
      read2(24'h000020, r0, r1);
      check("rd20_b0", {24'b0, r0}, 32'hFF);

      // Address wrap on program and read
      cmd1(8'h06);
      pp2(24'h0000FF, 8'h3C, 8'hC3);
      wait_idle("wrap_pp_end");
      read2(24'h0000FF, r0, r1);
      check("wrap_b0", {24'b0, r0}, 32'h3C);
      check("wrap_b1", {24'b0, r1}, 32'hC3);

      rfsr(st);
      check("rfsr_idle", {24'b0, st}, 32'h80);

      // Bulk erase with status polling
      cmd1(8'h06);
      b0 = busy_cyc;
      cmd1(8'hC7);
      check("be_wel_clr", {31'b0, wel}, 0);
      check("be_busy", {31'b0, busy}, 1);
      rfsr(st);
      check("be_rfsr_busy", {24'b0, st}, 32'h00);
      for (int i = 0; i < 30; i++) begin
         rfsr(st);
         if (st == 8'h80) break;
      end
      check("be_rfsr_done", {24'b0, st}, 32'h80);
      check("be_busy_len", busy_cyc - b0, 456);
      read2(24'h000010, r0, r1);
      check("be_rd10", {r0, r1}, 32'hFFFF);
      read2(24'h0000FF, r0, r1);
      check("be_rdff", {r0, r1}, 32'hFFFF);

      // Sector erase; commands during busy are ignored
      cmd1(8'h06);
      pp2(24'h000040, 8'h77, 8'h88);
      wait_idle("pp40_end");
      cmd1(8'h06);
      cs_begin();
      send_hdr(8'hD8, 24'h000000);
      cs_end();
      check("se_busy", {31'b0, busy}, 1);
      cv0 = cv_cnt;
      h0  = d1_hi;
      cmd1(8'h06);
      check("busy_wren_ign", {31'b0, wel}, 0);
      cs_begin();
      xfer(8'h03, r0);
      xfer(8'h00, r1);
      cs_end();
      check("busy_rd_data", {r0, r1}, 32'h0000);
      check("busy_d1_quiet", d1_hi - h0, 0);
      check("busy_cmdv_cnt", cv_cnt - cv0, 2);
      check("se_still_busy", {31'b0, busy}, 1);
      wait_idle("se_end");
      read2(24'h000040, r0, r1);
      check("se_rd40", {r0, r1}, 32'hFFFF);

      // Reset in the middle of an erase sweep
      cmd1(8'h06);
      pp2(24'h0000F0, 8'h12, 8'h34);
      wait_idle("ppf0_end");
      cmd1(8'h06);
      cmd1(8'hC7);
      repeat (20) @(negedge clk);
      check("pre_rst_busy", {31'b0, busy}, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 0);
      check("mid_rst_wel", {31'b0, wel}, 0);
      check("mid_rst_d1", {31'b0, d1}, 0);
      check("mid_rst_cmd", {24'b0, cmd}, 0);
      check("mid_rst_cmdv", {31'b0, cmdv}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rfsr(st);
      check("post_rst_rfsr", {24'b0, st}, 32'h80);
      read2(24'h0000F0, r0, r1);
      check("partial_erase", {r0, r1}, 32'h1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
